// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the DDS phase path
package dds_pkg;

  // Width of the config struct as seen by software and the lookup stage.
  localparam int CFG_ACC_DW = 32;

  // Config word layout: offset in the upper half, increment in the lower.
  typedef struct packed {
    logic [CFG_ACC_DW-1:0] offset;
    logic [CFG_ACC_DW-1:0] increment;
  } phase_cfg_t;

  // 32-bit Galois LFSR taps and a nonzero power-up seed for the dither.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

endpackage

// File: rtl/phase_accumulator_if.sv
// rtl/phase_accumulator_if.sv - config and phase stream bundle
interface phase_accumulator_if #(
  parameter int PHASE_DW = 16,
  parameter int ACC_DW   = 32
);
  logic [2*ACC_DW-1:0] s_axis_cfg_tdata;
  logic                s_axis_cfg_tvalid;
  logic                s_axis_cfg_tready;
  logic                enable;
  logic                sync_clear;
  logic [PHASE_DW-1:0] m_axis_phase_tdata;
  logic                m_axis_phase_tvalid;

  // Controller side: issues config, enable and re-sync, consumes phase.
  modport master (
    output s_axis_cfg_tdata, s_axis_cfg_tvalid, enable, sync_clear,
    input  s_axis_cfg_tready, m_axis_phase_tdata, m_axis_phase_tvalid
  );

  // Phase generator side.
  modport slave (
    input  s_axis_cfg_tdata, s_axis_cfg_tvalid, enable, sync_clear,
    output s_axis_cfg_tready, m_axis_phase_tdata, m_axis_phase_tvalid
  );
endinterface

// File: rtl/phase_accumulator_lfsr_gen.sv
// rtl/phase_accumulator_lfsr_gen.sv - Galois LFSR used as phase dither source
module lfsr_gen
  import dds_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] POLY = WIDTH'(LFSR_POLY);
  localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);

  logic [WIDTH-1:0] shifted;

  assign shifted = {1'b0, state[WIDTH-1:1]};

  // Shift right, folding the taps in whenever a one falls out of bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= state[0] ? (shifted ^ POLY) : shifted;
    end
  end

endmodule

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - NCO phase accumulator with shadowed config and dither
module phase_accumulator
  import dds_pkg::*;
#(
  parameter int PHASE_DW  = 16,
  parameter int ACC_DW    = 32,
  parameter int DITHER_DW = 0
) (
  input logic                clk,
  input logic                reset,
  phase_accumulator_if.slave bus
);

  logic [ACC_DW-1:0]   acc;
  logic [ACC_DW-1:0]   act_inc;
  logic [ACC_DW-1:0]   act_off;
  logic [ACC_DW-1:0]   sh_inc;
  logic [ACC_DW-1:0]   sh_off;
  logic                pending;
  logic                apply;
  logic                cfg_hs;
  logic [ACC_DW-1:0]   inc_eff;
  logic [ACC_DW-1:0]   off_eff;
  logic [ACC_DW-1:0]   s1_phase;
  logic [ACC_DW-1:0]   s1_off;
  logic                s1_valid;
  logic [ACC_DW-1:0]   dither_ext;
  logic [ACC_DW-1:0]   sum;
  logic [PHASE_DW-1:0] out_data;
  logic                out_valid;

  assign bus.s_axis_cfg_tready   = !pending;
  assign bus.m_axis_phase_tdata  = out_data;
  assign bus.m_axis_phase_tvalid = out_valid;

  // Shadow is promoted on a sample boundary; the promoted values take
  // effect in the same cycle they are promoted.
  always_comb begin
    cfg_hs  = bus.s_axis_cfg_tvalid && !pending;
    apply   = pending && (bus.enable || bus.sync_clear);
    inc_eff = apply ? sh_inc : act_inc;
    off_eff = apply ? sh_off : act_off;
  end

  // Shadow capture and active config promotion.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_inc  <= '0;
      sh_off  <= '0;
      act_inc <= '0;
      act_off <= '0;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        act_inc <= sh_inc;
        act_off <= sh_off;
        pending <= 1'b0;
      end
      if (cfg_hs) begin
        sh_inc  <= bus.s_axis_cfg_tdata[ACC_DW-1:0];
        sh_off  <= bus.s_axis_cfg_tdata[2*ACC_DW-1:ACC_DW];
        pending <= 1'b1;
      end
    end
  end

  // Stage 1: accumulate; sync_clear re-zeroes the phase and suppresses the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      s1_phase <= '0;
      s1_off   <= '0;
      s1_valid <= 1'b0;
    end else if (bus.sync_clear) begin
      acc      <= '0;
      s1_valid <= 1'b0;
    end else if (bus.enable) begin
      s1_phase <= acc;
      s1_off   <= off_eff;
      s1_valid <= 1'b1;
      acc      <= acc + inc_eff;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // Dither is drawn once per emitted sample so the sequence is tied to samples.
  generate
    if (DITHER_DW > 0) begin : g_dither
      localparam logic [31:0] DITHER_MASK = 32'((64'd1 << DITHER_DW) - 64'd1);
      logic [31:0] lfsr_state;

      lfsr_gen #(.WIDTH(32)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (s1_valid),
        .state   (lfsr_state)
      );

      assign dither_ext = ACC_DW'(lfsr_state & DITHER_MASK);
    end else begin : g_no_dither
      assign dither_ext = '0;
    end
  endgenerate

  assign sum = s1_phase + s1_off + dither_ext;

  // Stage 2: truncate to the lookup width; data holds between samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= PHASE_DW'(sum >> (ACC_DW - PHASE_DW));
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// tb/tb_phase_accumulator.sv - scoreboard bench for phase_accumulator
module tb_phase_accumulator;
  import dds_pkg::*;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phase_accumulator_if #(.PHASE_DW(16), .ACC_DW(32)) bus0 ();
  phase_accumulator_if #(.PHASE_DW(16), .ACC_DW(32)) bus1 ();

  phase_accumulator #(.PHASE_DW(16), .ACC_DW(32), .DITHER_DW(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  phase_accumulator #(.PHASE_DW(16), .ACC_DW(32), .DITHER_DW(16)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int          checks = 0;
  int          failures = 0;
  int          ecount = 0;
  exp_t        q[2][$];
  logic [31:0] m_acc, m_inc, m_off, m_sh_inc, m_sh_off, m_lfsr;
  bit          m_pend;

  function automatic logic [31:0] lfsr_next(logic [31:0] s);
    return (s >> 1) ^ (LFSR_POLY * (s & 32'd1));
  endfunction

  function automatic logic [63:0] mk_cfg(logic [31:0] off, logic [31:0] inc);
    phase_cfg_t c;
    c.offset    = off;
    c.increment = inc;
    return c;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_inc = 0; m_off = 0; m_sh_inc = 0; m_sh_off = 0;
    m_pend = 1'b0;
    m_lfsr = LFSR_SEED;
    q[0].delete();
    q[1].delete();
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(bit en, bit clr, bit cv, logic [63:0] cd, bit rst);
    phase_cfg_t  c;
    logic [31:0] s;
    bit          hs;
    bus0.enable = en; bus0.sync_clear = clr;
    bus0.s_axis_cfg_tvalid = cv; bus0.s_axis_cfg_tdata = cd;
    bus1.enable = en; bus1.sync_clear = clr;
    bus1.s_axis_cfg_tvalid = cv; bus1.s_axis_cfg_tdata = cd;
    reset = rst;
    checks++;
    if (bus0.s_axis_cfg_tready !== !m_pend || bus1.s_axis_cfg_tready !== !m_pend) begin
      failures++;
      $display("FAIL tready cycle=%0d got=%b/%b want=%b", ecount,
               bus0.s_axis_cfg_tready, bus1.s_axis_cfg_tready, !m_pend);
    end
    @(posedge clk);
    ecount++;
    if (rst) begin
      model_reset();
    end else begin
      c  = cd;
      hs = cv && !m_pend;
      if (m_pend && (en || clr)) begin
        m_inc  = m_sh_inc;
        m_off  = m_sh_off;
        m_pend = 1'b0;
      end
      if (hs) begin
        m_sh_inc = c.increment;
        m_sh_off = c.offset;
        m_pend   = 1'b1;
      end
      if (clr) begin
        m_acc = 0;
      end else if (en) begin
        s = m_acc + m_off;
        q[0].push_back('{d: s[31:16], due: ecount + 1});
        s = m_acc + m_off + (m_lfsr & 32'h0000_FFFF);
        q[1].push_back('{d: s[31:16], due: ecount + 1});
        m_lfsr = lfsr_next(m_lfsr);
        m_acc  = m_acc + m_inc;
      end
    end
    #1;
    if (rst) begin
      checks++;
      if (bus0.m_axis_phase_tvalid !== 1'b0 || bus0.m_axis_phase_tdata !== 16'h0 ||
          bus1.m_axis_phase_tvalid !== 1'b0 || bus1.m_axis_phase_tdata !== 16'h0) begin
        failures++;
        $display("FAIL reset_out got v=%b/%b d=%h/%h want v=0 d=0000",
                 bus0.m_axis_phase_tvalid, bus1.m_axis_phase_tvalid,
                 bus0.m_axis_phase_tdata, bus1.m_axis_phase_tdata);
      end
    end
  endtask

  task automatic cfg_write(logic [31:0] off, logic [31:0] inc);
    step(1'b0, 1'b0, 1'b1, mk_cfg(off, inc), 1'b0);
  endtask

  task automatic run_en(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a sample.
  always @(negedge clk) begin
    logic        v [2];
    logic [15:0] d [2];
    exp_t        e;
    v[0] = bus0.m_axis_phase_tvalid; d[0] = bus0.m_axis_phase_tdata;
    v[1] = bus1.m_axis_phase_tvalid; d[1] = bus1.m_axis_phase_tdata;
    for (int i = 0; i < 2; i++) begin
      if (v[i] === 1'b1) begin
        checks++;
        if (q[i].size() == 0) begin
          failures++;
          $display("FAIL sample%0d_unexpected cycle=%0d got=%h want=none", i, ecount, d[i]);
        end else begin
          e = q[i].pop_front();
          if (d[i] !== e.d || e.due != ecount) begin
            failures++;
            $display("FAIL sample%0d cycle=%0d got=%h want=%h due=%0d", i, ecount, d[i], e.d, e.due);
          end
        end
      end else if (q[i].size() != 0 && q[i][0].due <= ecount) begin
        checks++;
        failures++;
        e = q[i].pop_front();
        $display("FAIL sample%0d_missing cycle=%0d got=tvalid %b want=%h", i, ecount, v[i], e.d);
      end
    end
  end

  initial begin
    model_reset();
    reset = 1'b1;
    bus0.enable = 0; bus0.sync_clear = 0; bus0.s_axis_cfg_tvalid = 0; bus0.s_axis_cfg_tdata = 0;
    bus1.enable = 0; bus1.sync_clear = 0; bus1.s_axis_cfg_tvalid = 0; bus1.s_axis_cfg_tdata = 0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

    // Unit step ramp: 0,1,2,...
    cfg_write(32'h0, 32'h0001_0000);
    run_en(8);

    // Quarter-turn steps with wrap.
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    cfg_write(32'h0, 32'h4000_0000);
    run_en(6);

    // Mid-stream update held pending across idle cycles.
    cfg_write(32'h8000_0000, 32'h0002_0000);
    idle(3);
    run_en(5);

    // sync_clear wins over enable.
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    run_en(3);

    // Config handshake in the same cycle as an enable.
    step(1'b1, 1'b0, 1'b1, mk_cfg(32'h1234_0000, 32'h0003_0000), 1'b0);
    run_en(3);

    // Reset with samples in flight.
    run_en(2);
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    run_en(3);

    // Dither: constant zero, then carry toggling against offset 0xFFFF.
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    run_en(10);
    cfg_write(32'h0000_FFFF, 32'h0);
    run_en(20);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0, {$urandom, $urandom}, $urandom_range(0, 99) == 0);
    end

    idle(4);
    checks++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d outstanding want=0", q[0].size(), q[1].size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
